lif_spike_monitor: RTL and testbench
====================================

Name: lif_spike_monitor

Overview:
Downstream observer stage for the LIF neuron. It consumes the neuron's spike and membrane outputs while the neuron is in its READ state (state == 2'b11). Over a programmable window of clock cycles it counts spikes and tracks the peak membrane value. At each window boundary it publishes a result record through a valid/ready handshake to the output mux or host readout logic.

Parameters:
WIN_W, 16, width of the window-length input and of the internal cycle counter
CNT_W, 8, width of the spike count; the count saturates at 2^CNT_W-1

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
state  input  2  neuron mode; monitoring is active only when state == 2'b11
spike  input  1  neuron spike output, sampled on rising clk
membrane_in  input  8  neuron membrane value, sampled on rising clk
win_len  input  WIN_W  window length in cycles; 0 disables monitoring; sampled at window start
result_ready  input  1  consumer accepts the current result
result_valid  output  1  a published result is held on the outputs
spike_count  output  CNT_W  spikes counted in the published window
peak_membrane  output  8  maximum membrane_in value seen in the published window
overrun  output  1  sticky flag: an unconsumed result was overwritten
min_isi  output  WIN_W  minimum inter-spike interval in the published window (see Optional Feature)

Behaviour:
- Clock and reset: one clock (clk). rst_n is asynchronous and active-low.
- Reset values: all outputs 0. The FSM goes to IDLE. Internal counters are 0.
- FSM states:
  - IDLE: entered when state != 2'b11 or win_len == 0. Goes to RUN when state == 2'b11 and win_len != 0. On that transition it latches win_len into len_q, sets cyc = 0, clears the accumulators and performs the cycle-0 accumulation.
  - RUN: each cycle with state == 2'b11:
    - acc_cnt += spike, saturating at 2^CNT_W-1.
    - acc_peak = max(acc_peak, membrane_in).
    - cyc increments.
    - When cyc == len_q-1 (the last cycle of the window), publish: acc values including this cycle's sample go to the output registers, and result_valid goes to 1 on the next edge.
    - The next window starts immediately without a gap: len_q is re-latched from win_len, cyc = 0 and the accumulators are cleared.
  - Abort: state leaving 2'b11 in RUN goes to IDLE. The partial window is discarded and no result is published. The held result and result_valid are unchanged.
- Window length: win_len == 1 publishes every cycle. Changing win_len mid-window has no effect until the next window starts.
- Handshake:
  - result_valid falls on the edge where result_valid && result_ready, unless a publish occurs on that same edge. In that case the new result loads and result_valid stays 1.
  - A publish while result_valid && !result_ready overwrites the outputs and sets overrun.
  - overrun clears only on reset.
- Outputs are registered and stable while result_valid is high and no publish occurs.
- Latency: a spike on the last window cycle is reflected in spike_count one edge later.
- Saturation: with CNT_W = 8, a window containing 300 spikes reports 255.

Optional Feature:
Macro: LIF_MON_ISI_EN.
- Defined:
  - An ISI counter counts cycles since the last spike within the window.
  - On each spike after the first in the window, acc_isi = min(acc_isi, distance in cycles). For example, spikes on cycles 2 and 5 give a distance of 3.
  - acc_isi resets to all-ones at window start and is published to min_isi.
  - If the window has fewer than 2 spikes, min_isi publishes all-ones.
- Not defined: min_isi is tied to 0 and no ISI logic is synthesised.

Test Plan:
- Reset: assert rst_n = 0 mid-RUN -> all outputs 0 immediately (asynchronous); after release with state = 11 and win_len = 4, the first result_valid appears 4 cycles later.
- Basic window: state = 11, win_len = 8, spikes on cycles 1, 3, 6, membrane peak 0xC8 on cycle 5, result_ready = 1 -> one-cycle result_valid with spike_count = 3, peak_membrane = 0xC8.
- Back-pressure: win_len = 4, result_ready held at 0 for 10 cycles -> result_valid stays 1, overrun = 1 after the second publish, and the outputs show the latest window; raising result_ready clears result_valid and overrun stays 1.
- Abort and simultaneous events: state drops to 01 on cycle 5 of an 8-cycle window -> no publish and the prior result is retained. Separately, result_ready = 1 on a publish edge -> result_valid stays 1 with the new data.
- Saturation and edge cases: spike = 1 continuously, win_len = 300 -> spike_count = 255; win_len = 0 -> FSM stays in IDLE and no result_valid ever; win_len = 1 -> result_valid every cycle.
- Optional feature: with LIF_MON_ISI_EN defined, spikes at cycles 2, 5, 7 of a 10-cycle window -> min_isi = 2; with a single spike -> min_isi = 0xFFFF; with the macro undefined -> min_isi = 0.

Source files
------------

// File: rtl/lif_spike_monitor.sv
// Windowed spike counter / membrane peak tracker for the LIF neuron READ state.
// Optional minimum inter-spike interval tracking is enabled by defining LIF_MON_ISI_EN.
module lif_spike_monitor #(
    parameter int WIN_W = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       state,
    input  logic             spike,
    input  logic [7:0]       membrane_in,
    input  logic [WIN_W-1:0] win_len,
    input  logic             result_ready,
    output logic             result_valid,
    output logic [CNT_W-1:0] spike_count,
    output logic [7:0]       peak_membrane,
    output logic             overrun,
    output logic [WIN_W-1:0] min_isi
);

    typedef enum logic {
        S_IDLE,
        S_RUN
    } fsm_t;

    fsm_t fsm_q, fsm_d;

    logic             active;
    logic             starting;
    logic             sample;
    logic             last;
    logic [WIN_W-1:0] len_q, cyc_q;
    logic [WIN_W-1:0] cur_len, cur_cyc;
    logic [CNT_W-1:0] acc_cnt_q, base_cnt, nxt_cnt;
    logic [7:0]       acc_peak_q, base_peak, nxt_peak;

    assign active = (state == 2'b11);

    // The IDLE->RUN edge samples cycle 0 itself, so the window view is muxed
    // between the latched values and the "fresh window" values.
    always_comb begin
        starting  = (fsm_q == S_IDLE) && active && (win_len != '0);
        sample    = starting || ((fsm_q == S_RUN) && active);
        cur_len   = starting ? win_len : len_q;
        cur_cyc   = starting ? '0 : cyc_q;
        base_cnt  = starting ? '0 : acc_cnt_q;
        base_peak = starting ? '0 : acc_peak_q;
        last      = sample && (cur_cyc == (cur_len - WIN_W'(1)));
        nxt_cnt   = (base_cnt == '1) ? base_cnt : base_cnt + CNT_W'(spike);
        nxt_peak  = (membrane_in > base_peak) ? membrane_in : base_peak;
    end

    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            S_IDLE: begin
                if (starting) begin
                    fsm_d = S_RUN;
                end
            end
            S_RUN: begin
                if (!active) begin
                    fsm_d = S_IDLE;
                end else if (last && (win_len == '0)) begin
                    fsm_d = S_IDLE;
                end
            end
            default: fsm_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q <= S_IDLE;
        end else begin
            fsm_q <= fsm_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q      <= '0;
            cyc_q      <= '0;
            acc_cnt_q  <= '0;
            acc_peak_q <= '0;
        end else if (sample) begin
            if (last) begin
                len_q      <= win_len;
                cyc_q      <= '0;
                acc_cnt_q  <= '0;
                acc_peak_q <= '0;
            end else begin
                len_q      <= cur_len;
                cyc_q      <= cur_cyc + WIN_W'(1);
                acc_cnt_q  <= nxt_cnt;
                acc_peak_q <= nxt_peak;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_valid  <= 1'b0;
            spike_count   <= '0;
            peak_membrane <= '0;
            overrun       <= 1'b0;
        end else if (last) begin
            result_valid  <= 1'b1;
            spike_count   <= nxt_cnt;
            peak_membrane <= nxt_peak;
            if (result_valid && !result_ready) begin
                overrun <= 1'b1;
            end
        end else if (result_valid && result_ready) begin
            result_valid <= 1'b0;
        end
    end

`ifdef LIF_MON_ISI_EN
    logic             seen_q, base_seen;
    logic [WIN_W-1:0] last_sp_q;
    logic [WIN_W-1:0] acc_isi_q, base_isi, nxt_isi, dist;

    always_comb begin
        base_seen = starting ? 1'b0 : seen_q;
        base_isi  = starting ? '1 : acc_isi_q;
        dist      = cur_cyc - last_sp_q;
        nxt_isi   = base_isi;
        if (spike && base_seen && (dist < base_isi)) begin
            nxt_isi = dist;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seen_q    <= 1'b0;
            last_sp_q <= '0;
            acc_isi_q <= '1;
        end else if (sample) begin
            if (last) begin
                seen_q    <= 1'b0;
                acc_isi_q <= '1;
            end else begin
                acc_isi_q <= nxt_isi;
                if (spike) begin
                    seen_q    <= 1'b1;
                    last_sp_q <= cur_cyc;
                end else begin
                    seen_q <= base_seen;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            min_isi <= '0;
        end else if (last) begin
            min_isi <= nxt_isi;
        end
    end
`else
    assign min_isi = '0;
`endif

endmodule

// File: tb/tb_lif_spike_monitor.sv
// Table-driven scoreboard bench for lif_spike_monitor plus directed corner sequences.
module tb_lif_spike_monitor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  state;
    logic        spike;
    logic [7:0]  membrane_in;
    logic [15:0] win_len;
    logic        result_ready;
    logic        result_valid;
    logic [7:0]  spike_count;
    logic [7:0]  peak_membrane;
    logic        overrun;
    logic [15:0] min_isi;

    lif_spike_monitor #(.WIN_W(16), .CNT_W(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .state        (state),
        .spike        (spike),
        .membrane_in  (membrane_in),
        .win_len      (win_len),
        .result_ready (result_ready),
        .result_valid (result_valid),
        .spike_count  (spike_count),
        .peak_membrane(peak_membrane),
        .overrun      (overrun),
        .min_isi      (min_isi)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned len;
        logic [15:0] mask;
        int unsigned pk_cyc;
        logic [7:0]  pk_val;
        logic [7:0]  exp_cnt;
        logic [7:0]  exp_peak;
        logic [15:0] exp_isi;
    } vec_t;

    typedef struct {
        logic [7:0]  cnt;
        logic [7:0]  peak;
        logic [15:0] isi;
    } res_t;

    vec_t vec[8];
    res_t exp_q[$];
    res_t sb_r;
    res_t push_r;
    int   checks = 0;
    int   errors = 0;
    logic sb_on  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (sb_on && rst_n && result_valid && result_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: result count %0h with empty queue", spike_count);
            end else begin
                sb_r = exp_q.pop_front();
                chk("sb_count", 32'(spike_count), 32'(sb_r.cnt));
                chk("sb_peak", 32'(peak_membrane), 32'(sb_r.peak));
                chk("sb_isi", 32'(min_isi), 32'(sb_r.isi));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int unsigned n;
        int unsigned vcnt;
        int unsigned found;

        //           len  mask     pk_cyc pk_val cnt  peak   isi
        vec[0] = '{8,  16'h004A, 5,  8'hC8, 8'd3,  8'hC8, 16'd2};
        vec[1] = '{10, 16'h00A4, 0,  8'h90, 8'd3,  8'h90, 16'd2};
        vec[2] = '{4,  16'h0001, 3,  8'hFF, 8'd1,  8'hFF, 16'hFFFF};
        vec[3] = '{1,  16'h0001, 0,  8'h41, 8'd1,  8'h41, 16'hFFFF};
        vec[4] = '{1,  16'h0000, 0,  8'h42, 8'd0,  8'h42, 16'hFFFF};
        vec[5] = '{16, 16'hFFFF, 15, 8'h80, 8'd16, 8'h80, 16'd1};
        vec[6] = '{5,  16'h0000, 2,  8'h20, 8'd0,  8'h20, 16'hFFFF};
        vec[7] = '{3,  16'h0005, 1,  8'h33, 8'd2,  8'h33, 16'd2};

        rst_n = 1'b0; state = 2'b00; spike = 1'b0; membrane_in = '0;
        win_len = '0; result_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 32'(result_valid), 32'd0);
        chk("rst_count", 32'(spike_count), 32'd0);
        chk("rst_peak", 32'(peak_membrane), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_isi", 32'(min_isi), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Back-to-back windows; win_len for the next window is presented on the last cycle.
        sb_on = 1'b1;
        result_ready = 1'b1;
        state = 2'b11;
        for (int i = 0; i < 8; i++) begin
            for (int c = 0; c < int'(vec[i].len); c++) begin
                spike = vec[i].mask[c];
                membrane_in = (c == int'(vec[i].pk_cyc)) ? vec[i].pk_val : 8'(c);
                win_len = 16'(vec[i].len);
                if (c == int'(vec[i].len) - 1) begin
                    if (i < 7) begin
                        win_len = 16'(vec[i+1].len);
                    end
                    push_r.cnt  = vec[i].exp_cnt;
                    push_r.peak = vec[i].exp_peak;
`ifdef LIF_MON_ISI_EN
                    push_r.isi  = vec[i].exp_isi;
`else
                    push_r.isi  = 16'd0;
`endif
                    exp_q.push_back(push_r);
                end
                tick();
            end
        end
        state = 2'b01;
        spike = 1'b0;
        repeat (3) @(negedge clk);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        sb_on = 1'b0;
        tick();

        // Abort on cycle 5 of an 8-cycle window keeps the previous result.
        win_len = 16'd8; state = 2'b11; spike = 1'b1; membrane_in = 8'hEE;
        vcnt = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (result_valid) vcnt++;
        end
        state = 2'b01;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (result_valid) vcnt++;
        end
        chk("abort_no_valid", vcnt, 32'd0);
        chk("abort_count_kept", 32'(spike_count), 32'd2);
        chk("abort_peak_kept", 32'(peak_membrane), 32'h33);

        // win_len = 1: a result every cycle, valid stays high through ready+publish.
        state = 2'b11; win_len = 16'd1; result_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            spike = k[0];
            membrane_in = 8'(k + 8'h10);
            tick();
            chk("len1_valid", 32'(result_valid), 32'd1);
            chk("len1_count", 32'(spike_count), 32'(k[0]));
            chk("len1_peak", 32'(peak_membrane), 32'(k + 8'h10));
        end
        state = 2'b01; spike = 1'b0;
        tick();
        tick();
        chk("len1_drop_valid", 32'(result_valid), 32'd0);

        // Saturation: 300 spikes report 255.
        state = 2'b11; win_len = 16'd300; spike = 1'b1; membrane_in = 8'h07;
        tick();
        win_len = 16'd0;
        n = 1;
        while (!result_valid && n < 400) begin
            tick();
            n++;
        end
        chk("sat_valid", 32'(result_valid), 32'd1);
        chk("sat_latency", n, 32'd300);
        chk("sat_count", 32'(spike_count), 32'd255);
        state = 2'b01; spike = 1'b0;
        tick();
        tick();

        // win_len = 0 keeps the monitor idle.
        state = 2'b11; win_len = 16'd0; spike = 1'b1;
        vcnt = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (result_valid) vcnt++;
        end
        chk("len0_no_valid", vcnt, 32'd0);
        state = 2'b01; spike = 1'b0;
        tick();

        // Back-pressure: two publishes with ready low, second overwrites and flags overrun.
        result_ready = 1'b0; state = 2'b11; win_len = 16'd4;
        for (int c = 0; c < 4; c++) begin
            spike = (c == 0);
            membrane_in = 8'h10;
            tick();
        end
        chk("bp_valid1", 32'(result_valid), 32'd1);
        chk("bp_overrun1", 32'(overrun), 32'd0);
        chk("bp_count1", 32'(spike_count), 32'd1);
        for (int c = 4; c < 8; c++) begin
            spike = 1'b1;
            membrane_in = (c == 6) ? 8'h77 : 8'h05;
            tick();
        end
        chk("bp_valid2", 32'(result_valid), 32'd1);
        chk("bp_overrun2", 32'(overrun), 32'd1);
        chk("bp_count2", 32'(spike_count), 32'd4);
        chk("bp_peak2", 32'(peak_membrane), 32'h77);
        spike = 1'b0;
        tick();
        tick();
        state = 2'b01;
        tick();
        chk("bp_hold_valid", 32'(result_valid), 32'd1);
        chk("bp_hold_count", 32'(spike_count), 32'd4);
        result_ready = 1'b1;
        tick();
        chk("bp_ack_valid", 32'(result_valid), 32'd0);
        chk("bp_ack_overrun", 32'(overrun), 32'd1);

        // Asynchronous reset mid-RUN with a held result and overrun set.
        result_ready = 1'b0; state = 2'b11; win_len = 16'd4; spike = 1'b1; membrane_in = 8'h55;
        repeat (6) tick();
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(result_valid), 32'd0);
        chk("arst_count", 32'(spike_count), 32'd0);
        chk("arst_peak", 32'(peak_membrane), 32'd0);
        chk("arst_overrun", 32'(overrun), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        found = 0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (result_valid) begin
                found = k;
                break;
            end
        end
        chk("arst_first_latency", found, 32'd4);
        chk("arst_first_count", 32'(spike_count), 32'd4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
